// File: rtl/triggered_pulse_sequencer_pkg.sv
// Shared types, default widths and timing helper for the triggered pulse sequencer.
package triggered_pulse_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DEFAULT_CNT_W = 32;
  localparam int DEFAULT_NUM_W = 16;

  // Widest counter the helper can handle; callers zero-extend into it.
  localparam int MAX_CNT_W = 64;

  // Low time between pulses: period minus high time, but never below one cycle.
  function automatic logic [MAX_CNT_W-1:0] eff_low_len(input logic [MAX_CNT_W-1:0] period,
                                                      input logic [MAX_CNT_W-1:0] w);
    if (period > w) return period - w;
    else            return MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/triggered_pulse_sequencer_phase_counter.sv
// Loadable down-counter that parks at zero; zero_o marks the last cycle of a phase.
module triggered_pulse_sequencer_phase_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)                cnt_q <= '0;
    else if (load_i)          cnt_q <= load_val_i;
    else if (cnt_q != '0)     cnt_q <= cnt_q - CNT_W'(1);
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/triggered_pulse_sequencer.sv
// Trigger-started pulse train: delay, N pulses of width W / period P, then DONE.
// Optional abort input enabled by defining TRIGGERED_PULSE_SEQUENCER_ABORT_EN.
module triggered_pulse_sequencer
  import triggered_pulse_sequencer_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int NUM_W = DEFAULT_NUM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             rearm,
`ifdef TRIGGERED_PULSE_SEQUENCER_ABORT_EN
  input  logic             abort,
`endif
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [NUM_W-1:0] cfg_num,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_idx
);

  state_e           state_q, state_d;
  logic             trig_q;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic             pulse_q, busy_q, done_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  logic             trig_event;
  logic [CNT_W-1:0] width_new, low_new;

  assign trig_event = trig & ~trig_q;
  assign width_new  = (cfg_width == '0) ? CNT_W'(1) : cfg_width;
  assign low_new    = CNT_W'(eff_low_len(MAX_CNT_W'(cfg_period), MAX_CNT_W'(width_new)));

  triggered_pulse_sequencer_phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase_counter (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .zero_o    (cnt_zero)
  );

  // Phase counters are loaded with length-1 on entry, so a phase ends when they read zero.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    low_d        = low_q;
    num_d        = num_q;
    idx_d        = idx_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (trig_event) begin
          width_d = width_new;
          low_d   = low_new;
          num_d   = cfg_num;
          if (cfg_num == '0) begin
            state_d = ST_DONE;
          end else if (cfg_delay == '0) begin
            state_d      = ST_HIGH;
            idx_d        = NUM_W'(1);
            cnt_load     = 1'b1;
            cnt_load_val = width_new - CNT_W'(1);
          end else begin
            state_d      = ST_DELAY;
            cnt_load     = 1'b1;
            cnt_load_val = cfg_delay - CNT_W'(1);
          end
        end
      end
      ST_DELAY, ST_LOW: begin
        if (cnt_zero) begin
          state_d      = ST_HIGH;
          idx_d        = idx_q + NUM_W'(1);
          cnt_load     = 1'b1;
          cnt_load_val = width_q - CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          if (idx_q == num_q) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_LOW;
            cnt_load     = 1'b1;
            cnt_load_val = low_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (rearm) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
`ifdef TRIGGERED_PULSE_SEQUENCER_ABORT_EN
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      idx_d        = '0;
      cnt_load     = 1'b1;
      cnt_load_val = '0;
    end
`endif
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      width_q <= '0;
      low_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig;
      width_q <= width_d;
      low_q   <= low_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      pulse_q <= (state_d == ST_HIGH);
      busy_q  <= (state_d == ST_DELAY) || (state_d == ST_HIGH) || (state_d == ST_LOW);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_idx = idx_q;

endmodule
